// File: rtl/perf_counter_sampler.sv
// Periodic performance-counter sweeper: reads a counter address range every
// period_i cycles into a sample FIFO. Optional clear-on-read: PERF_SAMPLER_CLEAR_EN.
module perf_counter_sampler #(
  parameter int XLEN        = 64,
  parameter int FifoDepth   = 8,
  parameter int PeriodWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic [4:0]             first_addr_i,
  input  logic [4:0]             last_addr_i,
  input  logic                   csr_busy_i,
  output logic [4:0]             pc_addr_o,
  output logic                   pc_we_o,
  output logic [XLEN-1:0]        pc_data_o,
  input  logic [XLEN-1:0]        pc_data_i,
  output logic                   smp_valid_o,
  input  logic                   smp_ready_i,
  output logic [4:0]             smp_addr_o,
  output logic [XLEN-1:0]        smp_data_o,
  output logic                   smp_last_o,
  output logic [7:0]             missed_o
);

  localparam int PtrW = $clog2(FifoDepth);

  typedef enum logic {IDLE, SWEEP} state_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            last;
  } sample_t;

  state_e                 state_q;
  logic [4:0]             cur_q;
  logic [4:0]             last_q;
  logic [PeriodWidth-1:0] timer_q;
  logic                   enable_q;
  logic [7:0]             missed_q;

  sample_t                fifo_mem [FifoDepth];
  logic [PtrW-1:0]        wptr_q;
  logic [PtrW-1:0]        rptr_q;
  logic [PtrW:0]          count_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   trigger;
  logic                   issue;
  logic                   pop;
  logic [PeriodWidth-1:0] reload;
  sample_t                head;
  sample_t                push_entry;

  assign fifo_full  = (count_q == (PtrW+1)'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign reload     = (period_i == '0) ? '0 : period_i - PeriodWidth'(1);
  assign trigger    = enable_i && enable_q && (timer_q == '0);
  assign issue      = (state_q == SWEEP) && !csr_busy_i && !fifo_full;
  assign pop        = !fifo_empty && smp_ready_i;

  assign push_entry = '{addr: cur_q, data: pc_data_i, last: (cur_q == last_q)};

  // Interval timer: reloads on enable rising edge and on each expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      enable_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      enable_q <= enable_i;
      if (!enable_i) begin
        timer_q <= '0;
      end else if (!enable_q || timer_q == '0) begin
        timer_q <= reload;
      end else begin
        timer_q <= timer_q - PeriodWidth'(1);
      end
    end
  end

  // Sweep FSM; cur_q is parked at 0 outside a sweep so it drives pc_addr_o directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
    end else if (!enable_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= SWEEP;
            cur_q   <= first_addr_i;
            last_q  <= (last_addr_i < first_addr_i) ? first_addr_i : last_addr_i;
          end
        end
        SWEEP: begin
          if (issue) begin
            if (cur_q == last_q) begin
              state_q <= IDLE;
              cur_q   <= '0;
            end else begin
              cur_q <= cur_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cur_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      missed_q <= '0;
    end else if (trigger && state_q == SWEEP && missed_q != 8'hFF) begin
      missed_q <= missed_q + 8'd1;
    end
  end

  // NOTE: the sample storage has no reset; only pointers and count need a
  // defined value, and outputs are gated while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      fifo_mem[wptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (issue) wptr_q <= wptr_q + PtrW'(1);
      if (pop)   rptr_q <= rptr_q + PtrW'(1);
      case ({issue, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head        = fifo_mem[rptr_q];
  assign smp_valid_o = !fifo_empty;
  assign smp_addr_o  = fifo_empty ? '0 : head.addr;
  assign smp_data_o  = fifo_empty ? '0 : head.data;
  assign smp_last_o  = fifo_empty ? 1'b0 : head.last;
  assign missed_o    = missed_q;
  assign pc_addr_o   = cur_q;
  assign pc_data_o   = '0;

`ifdef PERF_SAMPLER_CLEAR_EN
  // Clear shares the read cycle; the pushed sample is the pre-clear value.
  assign pc_we_o = issue;
`else
  assign pc_we_o = 1'b0;
`endif

endmodule
